// File: rtl/psram_spi_ctrl.sv
// APS6404 PSRAM SPI controller: power-on/reset/ID init, paged read/write bursts.
// Optional PSRAM_FAST_READ_EN: reads use 0x0B with one dummy byte.
module psram_spi_ctrl #(
  parameter int CLK_DIV       = 2,
  parameter int POR_CYCLES    = 7500,
  parameter int CE_GAP_CYCLES = 4,
  parameter int LEN_W         = 10,
  parameter int PAGE_BYTES    = 1024
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             init_done,
  output logic             id_ok,
  output logic [15:0]      dev_id,
  output logic             spiclk,
  output logic             mosi,
  input  logic             miso,
  output logic             ce_n
);

  localparam int PW   = $clog2(PAGE_BYTES);
  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CMAX = (POR_CYCLES > CE_GAP_CYCLES) ? POR_CYCLES
                                                     : CE_GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
`ifdef PSRAM_FAST_READ_EN
  localparam logic [7:0] RD_CMD = 8'h0B;
`else
  localparam logic [7:0] RD_CMD = 8'h03;
`endif

  typedef enum logic [3:0] {
    S_POR, S_RSTEN, S_RST, S_GAP, S_READID, S_IDLE,
    S_CMD, S_ADDR,
`ifdef PSRAM_FAST_READ_EN
    S_DUMMY,
`endif
    S_DATA
  } state_e;

  state_e           state_q, state_d, ret_q, ret_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       bi_q, bi_d;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             wr_q, wr_d;
  logic [7:0]       sh_q, sh_d, rx_q, rx_d;
  logic [DW-1:0]    div_q, div_d;
  logic [3:0]       hc_q, hc_d;
  logic             sck_q, sck_d, mosi_q, mosi_d, cen_q, cen_d;
  logic [7:0]       rdat_q, rdat_d;
  logic             rval_q, rval_d, done_q, done_d;
  logic             init_q, init_d, idok_q, idok_d;
  logic [15:0]      id_q, id_d;

  logic       xfer, div_end, bdone, ld, go_gap, wr_take;
  logic [7:0] ld_b;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_POR;
      ret_q   <= S_RST;
      cnt_q   <= '0;
      bi_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      sh_q    <= '0;
      rx_q    <= '0;
      div_q   <= '0;
      hc_q    <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cen_q   <= 1'b1;
      rdat_q  <= '0;
      rval_q  <= 1'b0;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
      idok_q  <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      bi_q    <= bi_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      div_q   <= div_d;
      hc_q    <= hc_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cen_q   <= cen_d;
      rdat_q  <= rdat_d;
      rval_q  <= rval_d;
      done_q  <= done_d;
      init_q  <= init_d;
      idok_q  <= idok_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    bi_d    = bi_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wr_d    = wr_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    div_d   = div_q;
    hc_d    = hc_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cen_d   = cen_q;
    rdat_d  = rdat_q;
    rval_d  = 1'b0;
    done_d  = 1'b0;
    init_d  = init_q;
    idok_d  = idok_q;
    id_d    = id_q;
    ld      = 1'b0;
    ld_b    = 8'h00;
    go_gap  = 1'b0;
    wr_take = 1'b0;

    xfer = state_q inside {S_RSTEN, S_RST, S_READID,
                           S_CMD, S_ADDR, S_DATA};
`ifdef PSRAM_FAST_READ_EN
    if (state_q == S_DUMMY) xfer = 1'b1;
`endif
    div_end = div_q == DW'(CLK_DIV - 1);
    bdone   = xfer && div_end && hc_q == 4'd15;

    // Bit shifter: even half-periods low, sample on rise, shift on fall
    if (xfer) begin
      if (div_end) begin
        div_d = '0;
        hc_d  = hc_q + 4'd1;
        if (!hc_q[0]) begin
          sck_d = 1'b1;
          rx_d  = {rx_q[6:0], miso};
        end else begin
          sck_d  = 1'b0;
          sh_d   = {sh_q[6:0], 1'b0};
          mosi_d = sh_q[6];
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    if (state_q == S_DATA && !wr_q && div_end && hc_q == 4'd14) begin
      rval_d = 1'b1;
      rdat_d = {rx_q[6:0], miso};
    end

    unique case (state_q)
      S_POR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(POR_CYCLES - 1)) begin
          state_d = S_RSTEN;
          ld      = 1'b1;
          ld_b    = 8'h66;
        end
      end
      S_RSTEN: if (bdone) begin
        go_gap = 1'b1;
        ret_d  = S_RST;
      end
      S_RST: if (bdone) begin
        go_gap = 1'b1;
        ret_d  = S_READID;
      end
      S_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(CE_GAP_CYCLES - 1)) begin
          state_d = ret_q;
          ld      = ret_q != S_IDLE;
          if (ret_q == S_RST) ld_b = 8'h99;
          else if (ret_q == S_READID) ld_b = 8'h9F;
          else ld_b = wr_q ? 8'h02 : RD_CMD;
          // First entry to IDLE completes init; later ones end a request
          if (ret_q == S_IDLE) begin
            done_d = init_q;
            init_d = 1'b1;
          end
        end
      end
      S_READID: if (bdone) begin
        bi_d = bi_q + 3'd1;
        ld   = bi_q != 3'd6;
        if (bi_q == 3'd4) id_d[15:8] = rx_q;
        if (bi_q == 3'd5) id_d[7:0]  = rx_q;
        if (bi_q == 3'd6) begin
          go_gap = 1'b1;
          ret_d  = S_IDLE;
          idok_d = id_q == 16'h0D5D;
        end
      end
      S_IDLE: if (req_valid && init_q) begin
        state_d = S_CMD;
        addr_d  = req_addr;
        len_d   = req_len;
        wr_d    = req_write;
        ld      = 1'b1;
        ld_b    = req_write ? 8'h02 : RD_CMD;
      end
      S_CMD: if (bdone) begin
        state_d = S_ADDR;
        bi_d    = '0;
        ld      = 1'b1;
        ld_b    = addr_q[23:16];
      end
      S_ADDR: if (bdone) begin
        bi_d = bi_q + 3'd1;
        ld   = 1'b1;
        if (bi_q == 3'd0) ld_b = addr_q[15:8];
        else if (bi_q == 3'd1) ld_b = addr_q[7:0];
        else begin
          state_d = S_DATA;
`ifdef PSRAM_FAST_READ_EN
          if (!wr_q) state_d = S_DUMMY;
`endif
          wr_take = wr_q;
        end
      end
`ifdef PSRAM_FAST_READ_EN
      S_DUMMY: if (bdone) begin
        state_d = S_DATA;
        ld      = 1'b1;
      end
`endif
      S_DATA: if (bdone) begin
        if (len_q == '0) begin
          go_gap = 1'b1;
          ret_d  = S_IDLE;
        end else begin
          len_d  = len_q - 1'b1;
          addr_d = addr_q + 24'd1;
          // Last byte of a page: close the frame and reissue
          if (&addr_q[PW-1:0]) begin
            go_gap = 1'b1;
            ret_d  = S_CMD;
          end else begin
            ld      = 1'b1;
            wr_take = wr_q;
          end
        end
      end
      default: ;
    endcase

    if (wr_take) ld_b = wr_data;
    if (ld) begin
      sh_d   = ld_b;
      mosi_d = ld_b[7];
      hc_d   = '0;
      div_d  = '0;
      sck_d  = 1'b0;
      cen_d  = 1'b0;
    end
    if (go_gap) begin
      state_d = S_GAP;
      cnt_d   = '0;
      bi_d    = '0;
      cen_d   = 1'b1;
      mosi_d  = 1'b0;
      sck_d   = 1'b0;
    end
  end

  always_comb begin
    req_ready = state_q == S_IDLE && init_q;
    wr_ready  = wr_take;
    rd_data   = rdat_q;
    rd_valid  = rval_q;
    done      = done_q;
    init_done = init_q;
    id_ok     = idok_q;
    dev_id    = id_q;
    spiclk    = sck_q;
    mosi      = mosi_q;
    ce_n      = cen_q;
  end

endmodule

// File: doc/psram_spi_ctrl.md
Name: psram_spi_ctrl

Overview:
Parametrised SPI-mode controller for the APS6404 PSRAM, replacing the single-purpose bring-up sequencer.
- Integrates its own bit-level SPI shifter.
- Runs power-on delay, reset sequence and ID check autonomously.
- Then serves variable-length read/write burst requests from a client through a valid/ready port.
- Splits bursts transparently at device page boundaries.
- Sits between the memory-test/user logic and the PSRAM pins.

Parameters:
CLK_DIV, 2, sysclk cycles per SCK half-period; legal range >=1.
POR_CYCLES, 7500, sysclk cycles of power-on wait (150 us at 50 MHz).
CE_GAP_CYCLES, 4, minimum sysclk cycles ce_n held high between commands.
LEN_W, 10, width of req_len.
PAGE_BYTES, 1024, device page size in bytes; must be a power of two.

Ports:
sysclk  in  1  system clock; single clock domain.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  controller accepts a request when req_valid && req_ready.
req_write  in  1  1 = write, 0 = read.
req_addr  in  24  byte start address.
req_len  in  LEN_W  byte count minus one.
wr_data  in  8  write byte; must be valid in any cycle wr_ready=1.
wr_ready  out  1  one-cycle pulse; wr_data is consumed this cycle.
rd_data  out  8  read byte.
rd_valid  out  1  one-cycle pulse; rd_data is valid.
done  out  1  one-cycle pulse after the last byte of a request, once ce_n has risen.
init_done  out  1  high once the init sequence completes; stays high until reset.
id_ok  out  1  high if MFID==8'h0D and KGD==8'h5D.
dev_id  out  16  {MFID, KGD} captured during init.
spiclk  out  1  SCK.
mosi  out  1  SI.
miso  in  1  SO.
ce_n  out  1  chip enable, active low.

Behaviour:
- Reset values: ce_n=1, spiclk=0, mosi=0, req_ready=0, wr_ready=0, rd_valid=0, done=0, init_done=0, id_ok=0, dev_id=0, state=POR. Async assert, sync deassert.
- SPI mode 0, MSB first. mosi is updated while spiclk is low. miso is sampled on the sysclk where spiclk rises. One byte takes 16*CLK_DIV sysclk cycles.
- State machine: POR -> RSTEN -> GAP -> RST -> GAP -> READID -> IDLE -> CMD -> ADDR -> DATA -> GAP -> (CMD | IDLE).
- POR: ce_n=1, spiclk=0, mosi=0 for exactly POR_CYCLES cycles.
- RSTEN/RST: send 8'h66, then 8'h99, each in its own ce_n-low frame, separated by GAP.
- READID: send 8'h9F plus 3 address bytes of 0, then read 3 bytes. Capture byte0 as MFID and byte1 as KGD. Set id_ok, then init_done. init_done rises even if the ID check fails.
- IDLE: req_ready=1 only in IDLE with init_done=1. On handshake, latch addr, len and write, and drop req_ready the next cycle.
- CMD: send 8'h02 (write) or 8'h03 (read). ADDR: send 3 address bytes, MSB first.
- DATA, write: wr_ready pulses one cycle before each byte's first SCK edge, and wr_data is latched that cycle.
- DATA, read: rd_valid pulses the cycle after a byte's 8th bit is sampled.
- Byte counter decrements per byte. The frame ends when the counter hits 0 (req_len+1 bytes total).
- Page split: if the byte just transferred has addr[log2(PAGE_BYTES)-1:0] == PAGE_BYTES-1 and bytes remain:
  - raise ce_n, hold GAP;
  - reissue CMD/ADDR with the incremented address;
  - continue DATA. Byte stream order and count at the client are unchanged.
- Address arithmetic is 24-bit modulo: 24'hFFFFFF + 1 wraps to 0. This is always a page boundary, so it also triggers a split.
- GAP: ce_n high, spiclk low for CE_GAP_CYCLES. done pulses on the GAP exit to IDLE.
- req_valid during a burst is ignored: req_ready is 0 and the request is not queued.
- Reset mid-burst: ce_n returns high asynchronously, and the full POR and init sequence reruns.

Optional Feature:
PSRAM_FAST_READ_EN
- Defined: reads use command 8'h0B, with 8 dummy SCK cycles (one dummy byte, mosi=0) inserted between ADDR and DATA, including on page-split reissue. Writes are unchanged.
- Undefined: reads use 8'h03 with no wait state, and the dummy-state logic is absent.

Test Plan:
- Reset release with CLK_DIV=2 -> ce_n stays 1 and spiclk 0 for 7500 cycles. Next, frames carrying 8'h66 then 8'h99 appear, separated by >=4 high cycles.
- Model returns 0D,5D,xx after 9F 000000 -> dev_id=16'h0D5D, id_ok=1, init_done=1, req_ready=1. Model returns KGD=8'h55 -> id_ok=0, init_done=1.
- Write addr=24'h000010, len=3, data A1..A4 -> MOSI shows 02 00 00 10 A1 A2 A3 A4 in one frame, 4 wr_ready pulses, 1 done. A read of the same address returns A1..A4 on 4 rd_valid pulses.
- Write addr=24'h0003FE, len=3 -> frame 1 is 02 00 03 FE + 2 bytes, ce_n high >=4 cycles, frame 2 is 02 00 04 00 + 2 bytes. One done.
- Read addr=24'hFFFFFF, len=1 -> frames 03 FF FF FF + 1 byte, then 03 00 00 00 + 1 byte. 2 rd_valid pulses.
- Assert rst_n=0 mid-DATA -> ce_n=1 immediately, and init_done=0 until the sequence repeats. With PSRAM_FAST_READ_EN, a read shows 0B, addr, 8 dummy clocks, then data.
